syscall_unit: RTL and testbench
===============================

SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 Parameter HEAP_BASE, default 32'h00000080, SHALL set the initial heap pointer for sbrk.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 sc_req  input  1  SHALL indicate that the core is executing a syscall; the core holds it high while sc_stall is high.
REQ-005 v0  input  32  SHALL carry the service code ($v0), held stable by the core while sc_req is high.
REQ-006 a0  input  32  SHALL carry the argument ($a0), held stable by the core while sc_req is high.
REQ-007 sc_stall  output  1  SHALL, when high, freeze PC and register writes in the core.
REQ-008 rf_we  output  1  SHALL write rf_wdata into $v0 (register 2) when high.
REQ-009 rf_wdata  output  32  SHALL carry the $v0 write value.
REQ-010 mem_rd  output  1  SHALL request a data-memory word read.
REQ-011 mem_addr  output  32  SHALL carry a word-aligned read address.
REQ-012 mem_rdata  input  32  SHALL carry read data, valid one cycle after mem_rd.
REQ-013 tx_valid  output  1  SHALL indicate a console byte is offered.
REQ-014 tx_data  output  8  SHALL carry the console byte.
REQ-015 tx_ready  input  1  SHALL indicate the console accepts the byte.
REQ-016 halted  output  1  SHALL indicate that an exit has been executed.
REQ-017 heap_ptr  output  32  SHALL carry the current heap pointer.

Function
REQ-018 States SHALL be IDLE, INT, STR_RD, STR_WT, STR_TX, CHAR, DONE, HALT.
REQ-019 sc_stall SHALL equal sc_req & (state != DONE) combinationally, plus 1 in HALT.
REQ-020 In IDLE with sc_req=1, the unit SHALL latch a0 and dispatch on v0 as follows: 1 to INT, 4 to STR_RD, 9/10/11 as below, any other value to DONE.
REQ-021 DONE SHALL last exactly one cycle (stall low, so the PC advances), then return to IDLE; sc_req SHALL be ignored in DONE.
REQ-022 sbrk (v0=9) SHALL go to DONE with rf_we=1 and rf_wdata=old heap_ptr during DONE, and heap_ptr SHALL become old+((a0+3)&~3) mod 2^32 at the end of DONE.
REQ-023 exit (v0=10) SHALL go to HALT; halted=1 and sc_stall=1 until reset.
REQ-024 print_char (v0=11) SHALL offer a0[7:0] in CHAR, then go to DONE after the transfer.
REQ-025 A byte SHALL transfer on a cycle with tx_valid & tx_ready; tx_data SHALL stay stable and tx_valid SHALL stay high until that cycle.
REQ-026 print_string: STR_RD SHALL pulse mem_rd with mem_addr={p[31:2],2'b00}, where p starts at a0.
REQ-027 print_string: the byte SHALL be selected little-endian by p[1:0] (00 = bits 7:0).
REQ-028 print_string: a zero byte SHALL end the string and go to DONE without being emitted; otherwise the byte SHALL be emitted in STR_TX, p SHALL increment, and the unit SHALL return to STR_RD.
REQ-029 print_int SHALL emit the signed decimal of a0 in ASCII, most significant digit first: '-' if negative, no leading zeros, "0" for zero, and -2147483648 emitted correctly.
REQ-030 print_int SHALL complete within 110 cycles, excluding cycles with tx_valid=1 and tx_ready=0.
REQ-031 All outputs not asserted by the current state SHALL be 0.

Reset
REQ-032 When reset=0 at a clock edge, the unit SHALL enter IDLE, set heap_ptr=HEAP_BASE, clear halted, and deassert rf_we, mem_rd and tx_valid; mem_addr, tx_data and rf_wdata SHALL be 0.
REQ-033 Reset SHALL abort any service mid-operation; no further bytes SHALL be emitted after the reset edge.

Configuration
REQ-034 With SYSCALL_PRINT_INT_EN defined, v0=1 SHALL behave per REQ-029 and REQ-030.
REQ-035 Without SYSCALL_PRINT_INT_EN, v0=1 SHALL be treated as an unknown code (IDLE to DONE, no output), and the decimal-conversion logic SHALL be absent.

Verification
REQ-036 sbrk twice after reset, a0=5 then a0=8 -> rf_wdata 0x80 then 0x88; heap_ptr 0x90; each call has stall high for exactly 1 cycle.
REQ-037 print_char with a0=0x141 and tx_ready low for 3 cycles -> tx_data 0x41 held for 4 cycles, one transfer, then DONE.
REQ-038 print_string, a0=0x102, memory[0x100]=0x6948_0000, memory[0x104]=0x0000_0021 -> bytes 'H','i','!', then DONE.
REQ-039 print_int with a0=0x8000_0000 and with a0=0 -> "-2147483648" and "0"; without SYSCALL_PRINT_INT_EN -> no bytes.
REQ-040 exit, then sc_req=0 for 10 cycles -> halted=1 and stall=1 throughout; reset low asserted mid print_string -> tx_valid 0 after the edge and heap_ptr=0x80.

Source files
------------

// File: rtl/syscall_unit.sv
// syscall_unit: services SPIM-style syscalls for a single-issue core.
// Holds the core in stall while a service runs; supports print_int (1),
// print_string (4), sbrk (9), exit (10) and print_char (11).
// Optional feature macro: SYSCALL_PRINT_INT_EN enables the print_int decimal
// converter; without it, code 1 is treated like any unknown service.
module syscall_unit #(
  parameter logic [31:0] HEAP_BASE = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sc_req,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        sc_stall,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] heap_ptr
);

  typedef enum logic [2:0] {IDLE, INT, STR_RD, STR_WT, STR_TX, CHAR, DONE, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] arg;      // latched a0; doubles as the string pointer
  logic        is_sbrk;  // current service writes $v0 in DONE
  logic [7:0]  tx_byte;  // string byte being offered
  logic [7:0]  rd_byte;

  // Little-endian lane of the fetched word addressed by the string pointer.
  always_comb begin
    case (arg[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
  end

`ifdef SYSCALL_PRINT_INT_EN
  logic [31:0] mag;        // remaining magnitude still to be printed
  logic [3:0]  idx;        // decimal position being examined (9 = 10^9)
  logic        started;    // a non-zero digit has been emitted already
  logic        int_pend;   // int_byte is being offered on the console
  logic        int_last;   // int_byte is the units digit
  logic [7:0]  int_byte;
  logic [3:0]  digit;
  logic [31:0] digit_sub;
  logic [33:0] prod;
  logic        digit_emit;

  function automatic logic [33:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    pow10 = 34'd1;
      4'd1:    pow10 = 34'd10;
      4'd2:    pow10 = 34'd100;
      4'd3:    pow10 = 34'd1_000;
      4'd4:    pow10 = 34'd10_000;
      4'd5:    pow10 = 34'd100_000;
      4'd6:    pow10 = 34'd1_000_000;
      4'd7:    pow10 = 34'd10_000_000;
      4'd8:    pow10 = 34'd100_000_000;
      4'd9:    pow10 = 34'd1_000_000_000;
      default: pow10 = 34'd0;
    endcase
  endfunction

  // Current digit: the largest k with k*10^idx <= mag, found in one cycle.
  always_comb begin
    digit     = '0;
    digit_sub = '0;
    prod      = '0;
    for (int k = 1; k <= 9; k++) begin
      prod = 34'(k) * pow10(idx);
      if ({2'b00, mag} >= prod) begin
        digit     = 4'(k);
        digit_sub = prod[31:0];
      end
    end
  end

  // Leading zeros are suppressed, but the units digit always prints.
  assign digit_emit = (digit != 4'd0) || started || (idx == 4'd0);

  // Decimal conversion: optional sign first, then one digit per position.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mag      <= '0;
      idx      <= '0;
      started  <= 1'b0;
      int_pend <= 1'b0;
      int_last <= 1'b0;
      int_byte <= '0;
    end else if (state == IDLE && sc_req) begin
      // Two's-complement negate also maps 0x8000_0000 to 2^31 unsigned.
      mag      <= a0[31] ? (~a0 + 32'd1) : a0;
      idx      <= 4'd9;
      started  <= 1'b0;
      int_pend <= a0[31];
      int_last <= 1'b0;
      int_byte <= 8'h2D;
    end else if (state == INT) begin
      if (int_pend) begin
        if (tx_ready) int_pend <= 1'b0;
      end else begin
        if (digit_emit) begin
          int_byte <= 8'h30 + {4'h0, digit};
          int_pend <= 1'b1;
          started  <= 1'b1;
          mag      <= mag - digit_sub;
          int_last <= (idx == 4'd0);
        end
        if (idx != 4'd0) idx <= idx - 4'd1;
      end
    end
  end
`endif

  // Next-state logic: dispatch on v0 in IDLE, then walk the chosen service.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sc_req) begin
          case (v0)
            32'd4:   state_nxt = STR_RD;
            32'd10:  state_nxt = HALT;
            32'd11:  state_nxt = CHAR;
`ifdef SYSCALL_PRINT_INT_EN
            32'd1:   state_nxt = INT;
`endif
            default: state_nxt = DONE;
          endcase
        end
      end
`ifdef SYSCALL_PRINT_INT_EN
      INT:     if (int_pend && tx_ready && int_last) state_nxt = DONE;
`endif
      STR_RD:  state_nxt = STR_WT;
      STR_WT:  state_nxt = (rd_byte == 8'd0) ? DONE : STR_TX;
      STR_TX:  if (tx_ready) state_nxt = STR_RD;
      CHAR:    if (tx_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: only the current state's outputs are non-zero.
  always_comb begin
    sc_stall = (sc_req && state != DONE) || (state == HALT);
    rf_we    = 1'b0;
    rf_wdata = '0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    tx_valid = 1'b0;
    tx_data  = '0;
    halted   = 1'b0;
    case (state)
      DONE: begin
        if (is_sbrk) begin
          rf_we    = 1'b1;
          rf_wdata = heap_ptr;
        end
      end
      STR_RD: begin
        mem_rd   = 1'b1;
        mem_addr = {arg[31:2], 2'b00};
      end
      STR_TX: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
      end
      CHAR: begin
        tx_valid = 1'b1;
        tx_data  = arg[7:0];
      end
`ifdef SYSCALL_PRINT_INT_EN
      INT: begin
        tx_valid = int_pend;
        tx_data  = int_pend ? int_byte : 8'h00;
      end
`endif
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // State register plus argument, string byte and heap bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state    <= IDLE;
      heap_ptr <= HEAP_BASE;
      arg      <= '0;
      is_sbrk  <= 1'b0;
      tx_byte  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (sc_req) begin
            arg     <= a0;
            is_sbrk <= (v0 == 32'd9);
          end
        end
        STR_WT: tx_byte <= rd_byte;
        STR_TX: if (tx_ready) arg <= arg + 32'd1;
        DONE:   if (is_sbrk) heap_ptr <= heap_ptr + ((arg + 32'd3) & ~32'd3);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// tb_syscall_unit: randomized self-checking bench for syscall_unit.
// Honours SYSCALL_PRINT_INT_EN the same way as the design.
`timescale 1ns/1ps
module tb_syscall_unit;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        sc_req;
  logic [31:0] v0, a0, mem_rdata;
  logic        tx_ready;
  logic        sc_stall, rf_we, mem_rd, tx_valid, halted;
  logic [31:0] rf_wdata, mem_addr, heap_ptr;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_b [0:1023];
  logic [31:0] heap_m;
  bq_t         tx_q;
  logic        pend_rd;
  logic [9:0]  pend_addr;

  // Results of the most recent run_service call.
  int          r_stall, r_wait, r_valid, r_hold_err, r_zero_err;
  bit          r_done, r_we;
  logic [31:0] r_wdata;

  always #5 clk = ~clk;

  syscall_unit dut (
    .clk       (clk),
    .reset     (reset),
    .sc_req    (sc_req),
    .v0        (v0),
    .a0        (a0),
    .sc_stall  (sc_stall),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halted    (halted),
    .heap_ptr  (heap_ptr)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] addr);
    logic [9:0] b;
    b = {addr[9:2], 2'b00};
    return {mem_b[b + 10'd3], mem_b[b + 10'd2], mem_b[b + 10'd1], mem_b[b]};
  endfunction

  function automatic string q2hex(input bq_t q);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // Console bytes each service should produce, from the service definitions.
  function automatic bq_t model_bytes(input logic [31:0] code, input logic [31:0] arg);
    bq_t        q;
    string      s;
    logic [9:0] p;
    logic [7:0] b;
    case (code)
      32'd11: q.push_back(arg[7:0]);
      32'd4: begin
        p = arg[9:0];
        for (int i = 0; i < 1024; i++) begin
          b = mem_b[p];
          if (b == 8'h00) break;
          q.push_back(b);
          p = p + 10'd1;
        end
      end
`ifdef SYSCALL_PRINT_INT_EN
      32'd1: begin
        s = $sformatf("%0d", $signed(arg));
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      end
`endif
      default: ;
    endcase
    return q;
  endfunction

  task automatic place_string(input logic [9:0] base, input int len);
    for (int i = 0; i < len; i++) mem_b[base + 10'(i)] = 8'($urandom_range(1, 255));
    mem_b[base + 10'(len)] = 8'h00;
  endtask

  // Issue one syscall and observe it cycle by cycle until the DONE cycle.
  // Called at 1ns after a rising edge with the unit in IDLE.
  task automatic run_service(input logic [31:0] code, input logic [31:0] arg,
                             input int low_cycles, input int rdy_pct, input int budget);
    int         low_left;
    logic       prev_hold;
    logic [7:0] prev_data;
    low_left  = low_cycles;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    tx_q.delete();
    r_stall = 0; r_wait = 0; r_valid = 0; r_hold_err = 0; r_zero_err = 0;
    r_done = 0; r_we = 0; r_wdata = '0;
    pend_rd = 1'b0;
    v0 = code; a0 = arg; sc_req = 1'b1;
    for (int c = 0; c < budget && !r_done; c++) begin
      tx_ready  = (low_left > 0) ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
      mem_rdata = pend_rd ? mem_word(pend_addr) : $urandom;
      #1;
      if (prev_hold && (!tx_valid || tx_data !== prev_data)) r_hold_err++;
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if ((!mem_rd && mem_addr !== 32'd0) || (!tx_valid && tx_data !== 8'd0) ||
          (!rf_we && rf_wdata !== 32'd0) || (mem_rd && mem_addr[1:0] !== 2'b00) || halted)
        r_zero_err++;
      pend_rd   = mem_rd;
      pend_addr = mem_addr[9:0];
      if (tx_valid) begin
        r_valid++;
        if (tx_ready) tx_q.push_back(tx_data);
        else begin
          r_wait++;
          if (low_left > 0) low_left--;
        end
      end
      if (sc_stall) r_stall++;
      if (rf_we) begin r_we = 1; r_wdata = rf_wdata; end
      if (!sc_stall) r_done = 1;
      @(posedge clk); #1;
    end
    sc_req = 1'b0; v0 = '0; a0 = '0; tx_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; sc_req = 1'b0; v0 = '0; a0 = '0; tx_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({sc_stall, rf_we, mem_rd, tx_valid, halted} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {sc_stall, rf_we, mem_rd, tx_valid, halted});
    end
    n_checks++;
    if ({rf_wdata, mem_addr, tx_data} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h expected all zero", rf_wdata, mem_addr, tx_data);
    end
    n_checks++;
    if (heap_ptr !== 32'h80) begin
      n_fail++;
      $display("FAIL reset_heap: got %h expected 00000080", heap_ptr);
    end
    heap_m = 32'h80;
    reset  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sbrk();
    logic [31:0] args[6];
    logic [31:0] exp_w, exp_h;
    args = '{32'd5, 32'd8, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    args[4] = 32'($urandom_range(0, 4096));
    args[5] = $urandom;
    foreach (args[i]) begin
      exp_w = heap_m;
      exp_h = heap_m + 32'(((64'(args[i]) + 64'd3) / 64'd4) * 64'd4);
      run_service(32'd9, args[i], 0, 100, 20);
      n_checks++;
      if (!r_done || !r_we || r_wdata !== exp_w) begin
        n_fail++;
        $display("FAIL sbrk_wdata a0=%h: got done=%0d we=%0d data=%h expected %h", args[i], r_done, r_we, r_wdata, exp_w);
      end
      n_checks++;
      if (r_stall != 1) begin
        n_fail++;
        $display("FAIL sbrk_stall a0=%h: got %0d cycles expected 1", args[i], r_stall);
      end
      n_checks++;
      if (heap_ptr !== exp_h) begin
        n_fail++;
        $display("FAIL sbrk_heap a0=%h: got %h expected %h", args[i], heap_ptr, exp_h);
      end
      n_checks++;
      if (tx_q.size() != 0 || r_zero_err != 0) begin
        n_fail++;
        $display("FAIL sbrk_quiet: got %0d bytes, %0d stray outputs, expected 0 and 0", tx_q.size(), r_zero_err);
      end
      heap_m = exp_h;
    end
  endtask

  task automatic test_print_char();
    logic [31:0] arg;
    run_service(32'd11, 32'h141, 3, 100, 20);
    n_checks++;
    if (q2hex(tx_q) != "41 " || r_valid != 4 || r_stall != 5 || !r_done) begin
      n_fail++;
      $display("FAIL char_fixed: got bytes %s valid=%0d stall=%0d done=%0d expected 41 4 5 1", q2hex(tx_q), r_valid, r_stall, r_done);
    end
    n_checks++;
    if (r_hold_err != 0 || r_zero_err != 0 || r_we) begin
      n_fail++;
      $display("FAIL char_hold: got hold=%0d stray=%0d we=%0d expected 0 0 0", r_hold_err, r_zero_err, r_we);
    end
    repeat (4) begin
      arg = $urandom;
      run_service(32'd11, arg, 0, 40, 200);
      n_checks++;
      if (q2hex(tx_q) != q2hex(model_bytes(32'd11, arg)) || !r_done || r_hold_err != 0) begin
        n_fail++;
        $display("FAIL char_rand a0=%h: got %s done=%0d hold=%0d expected %s", arg, q2hex(tx_q), r_done, r_hold_err, q2hex(model_bytes(32'd11, arg)));
      end
    end
  endtask

  task automatic test_print_string();
    logic [9:0] base;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    {mem_b[10'h103], mem_b[10'h102], mem_b[10'h101], mem_b[10'h100]} = 32'h6948_0000;
    {mem_b[10'h107], mem_b[10'h106], mem_b[10'h105], mem_b[10'h104]} = 32'h0000_0021;
    run_service(32'd4, 32'h102, 0, 100, 100);
    n_checks++;
    if (q2hex(tx_q) != "48 69 21 " || !r_done || r_zero_err != 0) begin
      n_fail++;
      $display("FAIL str_fixed: got %s done=%0d stray=%0d expected 48 69 21", q2hex(tx_q), r_done, r_zero_err);
    end
    repeat (3) begin
      base = 10'($urandom_range(0, 900));
      place_string(base, $urandom_range(0, 10));
      run_service(32'd4, 32'(base), 0, 60, 400);
      n_checks++;
      if (q2hex(tx_q) != q2hex(model_bytes(32'd4, 32'(base))) || !r_done || r_hold_err != 0 || r_zero_err != 0) begin
        n_fail++;
        $display("FAIL str_rand p=%h: got %s done=%0d hold=%0d stray=%0d expected %s", base, q2hex(tx_q), r_done, r_hold_err, r_zero_err, q2hex(model_bytes(32'd4, 32'(base))));
      end
    end
  endtask

  task automatic test_print_int();
    logic [31:0] vals[8];
    vals = '{32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0, 32'd0};
    vals[5] = $urandom;
    vals[6] = $urandom;
    vals[7] = 32'($urandom_range(0, 999));
    foreach (vals[i]) begin
      run_service(32'd1, vals[i], 0, 70, 600);
      n_checks++;
      if (q2hex(tx_q) != q2hex(model_bytes(32'd1, vals[i])) || !r_done || r_hold_err != 0) begin
        n_fail++;
        $display("FAIL int_bytes a0=%h: got %s done=%0d hold=%0d expected %s", vals[i], q2hex(tx_q), r_done, r_hold_err, q2hex(model_bytes(32'd1, vals[i])));
      end
`ifdef SYSCALL_PRINT_INT_EN
      n_checks++;
      if (r_stall - r_wait > 110) begin
        n_fail++;
        $display("FAIL int_time a0=%h: got %0d cycles expected at most 110", vals[i], r_stall - r_wait);
      end
`else
      n_checks++;
      if (r_stall != 1 || r_we) begin
        n_fail++;
        $display("FAIL int_disabled a0=%h: got stall=%0d we=%0d expected 1 0", vals[i], r_stall, r_we);
      end
`endif
    end
  endtask

  task automatic test_unknown();
    logic [31:0] codes[$];
    logic [31:0] c;
    codes = {32'd0, 32'd2, 32'd3, 32'd12, 32'hFFFF_FFFF};
`ifndef SYSCALL_PRINT_INT_EN
    codes.push_back(32'd1);
`endif
    repeat (2) begin
      c = $urandom;
      while (c == 1 || c == 4 || c == 9 || c == 10 || c == 11) c = $urandom;
      codes.push_back(c);
    end
    foreach (codes[i]) begin
      run_service(codes[i], $urandom, 0, 100, 20);
      n_checks++;
      if (!r_done || r_stall != 1 || r_we || tx_q.size() != 0 || r_zero_err != 0 || heap_ptr !== heap_m) begin
        n_fail++;
        $display("FAIL unknown v0=%h: got done=%0d stall=%0d we=%0d bytes=%0d heap=%h expected 1 1 0 0 %h", codes[i], r_done, r_stall, r_we, tx_q.size(), heap_ptr, heap_m);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] code, arg, exp_w, exp_h;
    logic [9:0]  base;
    logic [31:0] menu[5];
    menu = '{32'd1, 32'd4, 32'd9, 32'd11, 32'd7};
    repeat (10) begin
      code  = menu[$urandom_range(0, 4)];
      arg   = $urandom;
      if (code == 32'd4) begin
        base = 10'($urandom_range(0, 1000));
        place_string(base, $urandom_range(0, 8));
        arg = 32'(base);
      end
      exp_w = heap_m;
      exp_h = (code == 32'd9) ? heap_m + 32'(((64'(arg) + 64'd3) / 64'd4) * 64'd4) : heap_m;
      run_service(code, arg, 0, 75, 600);
      n_checks++;
      if (q2hex(tx_q) != q2hex(model_bytes(code, arg)) || !r_done || r_we != (code == 32'd9) ||
          (r_we && r_wdata !== exp_w) || heap_ptr !== exp_h) begin
        n_fail++;
        $display("FAIL b2b v0=%0d a0=%h: got %s done=%0d we=%0d wdata=%h heap=%h expected %s wdata=%h heap=%h", code, arg, q2hex(tx_q), r_done, r_we, r_wdata, heap_ptr, q2hex(model_bytes(code, arg)), exp_w, exp_h);
      end
      heap_m = exp_h;
    end
  endtask

  task automatic test_reset_mid();
    int seen, after;
    bit hit;
    seen = 0; after = 0; hit = 0;
    run_service(32'd9, 32'd16, 0, 100, 20);
    heap_m = heap_m + 32'd16;
    n_checks++;
    if (heap_ptr !== heap_m) begin
      n_fail++;
      $display("FAIL rstmid_pre_heap: got %h expected %h", heap_ptr, heap_m);
    end
    place_string(10'h200, 8);
    v0 = 32'd4; a0 = 32'h200; sc_req = 1'b1; pend_rd = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      mem_rdata = pend_rd ? mem_word(pend_addr) : 32'd0;
      tx_ready  = (seen < 2);
      #1;
      pend_rd   = mem_rd;
      pend_addr = mem_addr[9:0];
      if (tx_valid && tx_ready) seen++;
      if (tx_valid && !tx_ready) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rstmid_reach: got no pending byte within 100 cycles expected one");
    end
    reset = 1'b0; sc_req = 1'b0; v0 = '0; a0 = '0;
    @(posedge clk); #2;
    n_checks++;
    if (tx_valid !== 1'b0 || heap_ptr !== 32'h80 || sc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: got tx_valid=%b heap=%h stall=%b expected 0 00000080 0", tx_valid, heap_ptr, sc_stall);
    end
    reset = 1'b1;
    heap_m = 32'h80;
    repeat (10) begin
      @(posedge clk); #1;
      tx_ready = 1'b1;
      #1;
      if (tx_valid) after++;
    end
    tx_ready = 1'b0;
    n_checks++;
    if (after != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got %0d offered bytes expected 0", after);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exit();
    v0 = 32'd10; a0 = $urandom; sc_req = 1'b1;
    #1;
    n_checks++;
    if (sc_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_issue_stall: got %b expected 1", sc_stall);
    end
    @(posedge clk); #1;
    sc_req = 1'b0; v0 = '0; a0 = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if ({halted, sc_stall, tx_valid, rf_we, mem_rd} !== 5'b11000) begin
        n_fail++;
        $display("FAIL exit_hold cycle %0d: got %b expected 11000", c, {halted, sc_stall, tx_valid, rf_we, mem_rd});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (halted !== 1'b0 || sc_stall !== 1'b0 || heap_ptr !== 32'h80) begin
      n_fail++;
      $display("FAIL exit_reset: got halted=%b stall=%b heap=%h expected 0 0 00000080", halted, sc_stall, heap_ptr);
    end
    heap_m = 32'h80;
    @(posedge clk); #1;
    run_service(32'd9, 32'd4, 0, 100, 20);
    n_checks++;
    if (!r_we || r_wdata !== 32'h80 || heap_ptr !== 32'h84) begin
      n_fail++;
      $display("FAIL exit_recover: got we=%0d wdata=%h heap=%h expected 1 00000080 00000084", r_we, r_wdata, heap_ptr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sbrk();
    test_print_char();
    test_print_string();
    test_print_int();
    test_unknown();
    test_back_to_back();
    test_reset_mid();
    test_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
